ifetch_r32i: RTL and testbench
==============================

# ifetch_r32i

Instruction fetch stage for the RISCV32I core, directly downstream of the PC module. It takes the current program address, runs a request/response handshake with instruction memory (variable latency, one request outstanding), and holds the fetched word in a single-entry output buffer for the decoder. It also tells the PC when to advance, and discards in-flight or buffered instructions on a branch flush.

## Interface
Parameters:
- dataW, 32, address and instruction width.
- NopInstr, 32'h00000013, value of Instr when no instruction is held (`addi x0,x0,0`).

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ProgAddr  in  dataW  current PC value from the PC module.
- Flush  in  1  branch taken this cycle; discard in-flight and buffered work.
- PCEnable  out  1  one-cycle pulse; the PC advances to its next address.
- IMemReq  out  1  memory request valid.
- IMemAddr  out  dataW  request address; held stable while IMemReq=1.
- IMemGnt  in  1  request accepted when IMemReq & IMemGnt.
- IMemRValid  in  1  response data valid.
- IMemRData  in  dataW  response instruction word.
- InstrValid  out  1  output buffer holds a valid instruction.
- InstrReady  in  1  decoder takes the instruction when InstrValid & InstrReady.
- Instr  out  dataW  buffered instruction.
- InstrAddr  out  dataW  address of the buffered instruction.
- FetchFault  out  1  buffered entry is a misaligned-fetch fault (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, DROP, FULL.
- IDLE: entered on reset. Moves to REQ on the next edge and latches IMemAddr <= ProgAddr.
- REQ: IMemReq=1.
  - On grant, go to WAIT and pulse PCEnable.
  - With no grant, stay in REQ. IMemAddr does not change.
- WAIT: on IMemRValid, capture Instr <= IMemRData, InstrAddr <= IMemAddr and InstrValid <= 1, then go to FULL.
- FULL: on InstrReady, clear InstrValid, latch IMemAddr <= ProgAddr and go to REQ.
- A request is only issued when the buffer is empty, so a response capture never overwrites a valid entry.
- DROP: wait for IMemRValid, discard the data, latch IMemAddr <= ProgAddr and go to REQ.
- Flush has priority over every other event. The new ProgAddr (the branch target) is valid on the cycle after Flush.
  - REQ, no grant: go to REQ, re-latch the address next cycle.
  - REQ with grant in the same cycle: go to DROP. PCEnable is suppressed (PCEnable = IMemReq & IMemGnt & ~Flush).
  - WAIT, no RValid: go to DROP.
  - WAIT with RValid in the same cycle: discard the data and go to REQ.
  - FULL: clear InstrValid and go to REQ. This applies even if InstrReady=1.
  - DROP: stay in DROP.
- Instr returns to NopInstr whenever InstrValid clears.

## Timing
- Reset values: IMemReq=0, IMemAddr=0, PCEnable=0, InstrValid=0, Instr=NopInstr, InstrAddr=0, FetchFault=0. State=IDLE.
- Reset mid-transaction abandons any outstanding response. The memory must not present RValid for a pre-reset request after reset deasserts.
- Best case, with a same-cycle grant and RValid one cycle later:
  - grant at cycle n
  - capture at edge n+1
  - InstrValid high during n+2
  - minimum 3 cycles per instruction with InstrReady held high.
- Latency to InstrValid is 2 + grant wait + response wait cycles.
- PCEnable is combinational from IMemGnt and is high at most once per request.
- Outputs other than PCEnable are registered.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - If ProgAddr[1:0] != 0 at address latch, no memory request is issued.
  - The block goes directly to FULL with FetchFault=1, Instr=NopInstr and InstrAddr=ProgAddr.
  - PCEnable is not pulsed.
  - FetchFault clears when the entry is consumed or flushed.
- Undefined:
  - Address bits [1:0] are forced to 0 in IMemAddr and InstrAddr.
  - FetchFault is tied to 0.

## Structure
- Shared package:
  - fetch state enum (IDLE, REQ, WAIT, DROP, FULL)
  - NOP encoding constant 32'h00000013
  - the FETCH_ALIGN_CHECK_EN guard comment
- No sub-module. The single FSM plus output register stays in one module.

## Test plan
- Reset released; memory grants immediately, RValid 1 cycle later with data 32'h00500093 at ProgAddr 0 -> InstrValid=1, Instr=32'h00500093, InstrAddr=0 on cycle 3; exactly one PCEnable pulse.
- IMemGnt held low 4 cycles -> IMemReq=1 and IMemAddr stable throughout; PCEnable only on the grant cycle.
- InstrReady low 5 cycles in FULL -> Instr/InstrValid held; IMemReq=0; the next request starts the cycle after InstrReady rises.
- Flush in WAIT, then RValid with 32'hDEADBEEF two cycles later -> word discarded, InstrValid stays 0; the next request uses the new ProgAddr (64).
- Flush in FULL with InstrReady=1 in the same cycle -> InstrValid cleared, Instr=NopInstr; request to the branch target follows.
- ProgAddr=32'h00000042 with FETCH_ALIGN_CHECK_EN -> no IMemReq, FetchFault=1, InstrAddr=32'h42; without the macro -> IMemAddr=32'h40.

Source files
------------

// File: rtl/ifetch_r32i_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// FETCH_ALIGN_CHECK_EN (optional) turns misaligned PCs into buffered fetch faults.
package ifetch_r32i_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_FULL
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch_r32i.sv
// RV32I fetch: one outstanding imem request into a single-entry buffer; FETCH_ALIGN_CHECK_EN faults misaligned PCs.
// Latency: 2 + grant wait + response wait cycles from address latch to InstrValid.
// Backpressure: no request is issued while the buffer is full; InstrReady low holds the entry.
module ifetch_r32i
    import ifetch_r32i_pkg::*;
#(
    parameter int unsigned      dataW    = 32,
    parameter logic [dataW-1:0] NopInstr = dataW'(NOP_INSTR)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    input  logic             Flush,
    output logic             PCEnable,
    output logic             IMemReq,
    output logic [dataW-1:0] IMemAddr,
    input  logic             IMemGnt,
    input  logic             IMemRValid,
    input  logic [dataW-1:0] IMemRData,
    output logic             InstrValid,
    input  logic             InstrReady,
    output logic [dataW-1:0] Instr,
    output logic [dataW-1:0] InstrAddr,
    output logic             FetchFault
);

    fetch_state_e     state_q, state_d;
    logic             relatch_q, relatch_d;
    logic [dataW-1:0] addr_q, addr_d;
    logic             vld_q, vld_d;
    logic [dataW-1:0] instr_q, instr_d;
    logic [dataW-1:0] iaddr_q, iaddr_d;
    logic             fault_q, fault_d;
    logic             latch_now;
    logic             misaligned;
    logic [dataW-1:0] prog_addr_aligned;

    assign prog_addr_aligned = {ProgAddr[dataW-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = |ProgAddr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // relatch_q marks REQ entered from a flush: the branch target only shows
    // up on ProgAddr a cycle later, so the request waits for it.
    assign IMemReq    = (state_q == S_REQ) && !relatch_q;
    assign PCEnable   = IMemReq & IMemGnt & ~Flush;
    assign IMemAddr   = addr_q;
    assign InstrValid = vld_q;
    assign Instr      = instr_q;
    assign InstrAddr  = iaddr_q;
    assign FetchFault = fault_q;

    always_comb begin
        state_d   = state_q;
        relatch_d = relatch_q;
        addr_d    = addr_q;
        vld_d     = vld_q;
        instr_d   = instr_q;
        iaddr_d   = iaddr_q;
        fault_d   = fault_q;
        latch_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!Flush) latch_now = 1'b1;
            end
            S_REQ: begin
                if (relatch_q) begin
                    if (!Flush) latch_now = 1'b1;
                end else if (Flush) begin
                    if (IMemGnt) state_d = S_DROP;
                    else         relatch_d = 1'b1;
                end else if (IMemGnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Flush) begin
                    if (IMemRValid) begin
                        state_d   = S_REQ;
                        relatch_d = 1'b1;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (IMemRValid) begin
                    state_d = S_FULL;
                    vld_d   = 1'b1;
                    instr_d = IMemRData;
                    iaddr_d = addr_q;
                end
            end
            S_DROP: begin
                // A flush landing on the discarded response still has to re-fetch.
                if (IMemRValid) begin
                    if (Flush) begin
                        state_d   = S_REQ;
                        relatch_d = 1'b1;
                    end else begin
                        latch_now = 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (Flush || InstrReady) begin
                    vld_d   = 1'b0;
                    instr_d = NopInstr;
                    fault_d = 1'b0;
                    if (Flush) begin
                        state_d   = S_REQ;
                        relatch_d = 1'b1;
                    end else begin
                        latch_now = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                relatch_d = 1'b0;
            end
        endcase

        if (latch_now) begin
            addr_d    = prog_addr_aligned;
            relatch_d = 1'b0;
            if (misaligned) begin
                state_d = S_FULL;
                vld_d   = 1'b1;
                fault_d = 1'b1;
                instr_d = NopInstr;
                iaddr_d = ProgAddr;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            relatch_q <= 1'b0;
            addr_q    <= '0;
            vld_q     <= 1'b0;
            instr_q   <= NopInstr;
            iaddr_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            relatch_q <= relatch_d;
            addr_q    <= addr_d;
            vld_q     <= vld_d;
            instr_q   <= instr_d;
            iaddr_q   <= iaddr_d;
            fault_q   <= fault_d;
        end
    end

endmodule

// File: tb/tb_ifetch_r32i.sv
// Directed bench for ifetch_r32i: a memory + PC model drives the DUT while a scoreboard
// checks every cycle; FETCH_ALIGN_CHECK_EN selects the expected misaligned-fetch outcome.
module tb_ifetch_r32i;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ProgAddr = '0;
    logic        Flush = 1'b0;
    logic        PCEnable;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt = 1'b0;
    logic        IMemRValid = 1'b0;
    logic [31:0] IMemRData = '0;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic [31:0] Instr;
    logic [31:0] InstrAddr;
    logic        FetchFault;

    always #5 clock = ~clock;

    ifetch_r32i dut (
        .clock      (clock),
        .reset      (reset),
        .ProgAddr   (ProgAddr),
        .Flush      (Flush),
        .PCEnable   (PCEnable),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemGnt    (IMemGnt),
        .IMemRValid (IMemRValid),
        .IMemRData  (IMemRData),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instr      (Instr),
        .InstrAddr  (InstrAddr),
        .FetchFault (FetchFault)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], 16'h0113};
    endfunction

    // Memory / PC model state
    int          gnt_delay = 0;
    int          rsp_delay = 1;
    int          req_wait  = 0;
    int          pend_cnt  = 0;
    logic        corrupt   = 1'b0;
    logic [31:0] pend_data = '0;
    logic [31:0] branch_tgt = '0;
    logic        pcen_q = 1'b0;
    logic        flush_q = 1'b0;
    int          pcen_cnt = 0;

    task automatic tick();
        @(posedge clock);
        #1;
        if (flush_q)     ProgAddr = branch_tgt;
        else if (pcen_q) ProgAddr = ProgAddr + 32'd4;
        Flush      = 1'b0;
        IMemRValid = 1'b0;
        IMemRData  = '0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                IMemRValid = 1'b1;
                IMemRData  = pend_data;
            end
        end
        IMemGnt = 1'b0;
        if (IMemReq) begin
            if (req_wait >= gnt_delay) begin
                IMemGnt   = 1'b1;
                req_wait  = 0;
                pend_cnt  = rsp_delay;
                pend_data = corrupt ? 32'hDEAD_BEEF : mem_word(IMemAddr);
            end else begin
                req_wait++;
            end
        end else begin
            req_wait = 0;
        end
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Scoreboard: words granted without a flush must reach the buffer in order.
    exp_t        exp_q[$];
    exp_t        e;
    logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_valid = 1'b0;
    logic        prev_ready = 1'b0, prev_flush = 1'b0;
    logic [31:0] prev_addr = '0, prev_instr = '0;

    always @(negedge clock) begin
        if (!reset) begin
            chk("pcen_rule", 32'(PCEnable), 32'(IMemReq & IMemGnt & ~Flush));
            if (IMemReq && prev_req && !prev_gnt)
                chk("addr_stable", IMemAddr, prev_addr);
            chk("no_req_when_full", 32'(IMemReq & InstrValid), 32'd0);
            if (!InstrValid)
                chk("nop_when_empty", Instr, NOP);
`ifndef FETCH_ALIGN_CHECK_EN
            chk("fault_tied_low", 32'(FetchFault), 32'd0);
            chk("addr_aligned", 32'(IMemAddr[1:0]), 32'd0);
`endif
            if (prev_valid && !prev_ready && !prev_flush) begin
                chk("hold_valid", 32'(InstrValid), 32'd1);
                chk("hold_instr", Instr, prev_instr);
            end
            if (InstrValid && !prev_valid) begin
                if (FetchFault) begin
                    chk("fault_nop", Instr, NOP);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got %h at %h, required no new entry", Instr, InstrAddr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", Instr, e.data);
                    chk("sb_addr", InstrAddr, e.addr);
                end
            end
            if (IMemReq && IMemGnt && !Flush) begin
                chk("fetch_addr_is_pc", IMemAddr, {ProgAddr[31:2], 2'b00});
                e.addr = IMemAddr;
                e.data = mem_word(IMemAddr);
                exp_q.push_back(e);
            end
            if (Flush) exp_q.delete();
            if (PCEnable) pcen_cnt++;
        end
        pcen_q     = PCEnable;
        flush_q    = Flush;
        prev_req   = IMemReq;
        prev_gnt   = IMemReq & IMemGnt;
        prev_addr  = IMemAddr;
        prev_valid = InstrValid;
        prev_ready = InstrReady;
        prev_flush = Flush;
        prev_instr = Instr;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        tick(); tick(); sample();
        chk("rst_req", 32'(IMemReq), 32'd0);
        chk("rst_addr", IMemAddr, 32'd0);
        chk("rst_pcen", 32'(PCEnable), 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", Instr, NOP);
        chk("rst_iaddr", InstrAddr, 32'd0);
        chk("rst_fault", 32'(FetchFault), 32'd0);

        // Best case fetch of address 0
        tick(); reset = 1'b0; sample();
        chk("idle_no_req", 32'(IMemReq), 32'd0);
        tick(); sample();
        chk("t1_req", 32'(IMemReq), 32'd1);
        chk("t1_addr", IMemAddr, 32'd0);
        chk("t1_pcen", 32'(PCEnable), 32'd1);
        tick(); sample();
        chk("t1_wait_valid", 32'(InstrValid), 32'd0);
        tick(); sample();
        chk("t1_valid", 32'(InstrValid), 32'd1);
        chk("t1_instr", Instr, 32'h0050_0093);
        chk("t1_iaddr", InstrAddr, 32'd0);
        chk("t1_pcen_cnt", 32'(pcen_cnt), 32'd1);
        chk("t1_pc", ProgAddr, 32'd4);

        // Decoder stalls for five cycles
        for (int i = 0; i < 4; i++) begin
            tick(); sample();
            chk("stall_valid", 32'(InstrValid), 32'd1);
            chk("stall_instr", Instr, 32'h0050_0093);
            chk("stall_req", 32'(IMemReq), 32'd0);
        end
        gnt_delay = 4;
        tick(); InstrReady = 1'b1; sample();
        chk("ready_cycle_req", 32'(IMemReq), 32'd0);
        chk("ready_cycle_valid", 32'(InstrValid), 32'd1);

        // Grant withheld four cycles
        tick(); InstrReady = 1'b0; sample();
        chk("t2_req", 32'(IMemReq), 32'd1);
        chk("t2_addr", IMemAddr, 32'd4);
        chk("t2_empty", 32'(InstrValid), 32'd0);
        chk("t2_nop", Instr, NOP);
        chk("t2_pcen", 32'(PCEnable), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); sample();
            chk("t2_req_hold", 32'(IMemReq), 32'd1);
            chk("t2_addr_hold", IMemAddr, 32'd4);
            chk("t2_pcen_low", 32'(PCEnable), 32'd0);
        end
        tick(); sample();
        chk("t2_gnt_pcen", 32'(PCEnable), 32'd1);
        chk("t2_gnt_addr", IMemAddr, 32'd4);
        gnt_delay = 0;
        tick(); sample();
        chk("t2_wait_valid", 32'(InstrValid), 32'd0);
        tick(); InstrReady = 1'b1; rsp_delay = 3; corrupt = 1'b1; sample();
        chk("t2_valid", 32'(InstrValid), 32'd1);
        chk("t2_instr", Instr, 32'h0004_0113);
        chk("t2_iaddr", InstrAddr, 32'd4);
        chk("t2_pcen_cnt", 32'(pcen_cnt), 32'd2);

        // Flush while waiting; late DEADBEEF response is dropped
        tick(); corrupt = 1'b0; sample();
        chk("t4_req", 32'(IMemReq), 32'd1);
        chk("t4_addr", IMemAddr, 32'd8);
        tick(); Flush = 1'b1; branch_tgt = 32'd64; sample();
        chk("t4_flush_pcen", 32'(PCEnable), 32'd0);
        chk("t4_flush_req", 32'(IMemReq), 32'd0);
        tick(); sample();
        chk("t4_drop_req", 32'(IMemReq), 32'd0);
        chk("t4_pc_target", ProgAddr, 32'd64);
        tick(); rsp_delay = 1; sample();
        chk("t4_rvalid_req", 32'(IMemReq), 32'd0);
        chk("t4_rvalid_empty", 32'(InstrValid), 32'd0);
        tick(); sample();
        chk("t4_new_req", 32'(IMemReq), 32'd1);
        chk("t4_new_addr", IMemAddr, 32'd64);
        chk("t4_still_empty", 32'(InstrValid), 32'd0);
        tick(); sample();
        chk("t4_wait_empty", 32'(InstrValid), 32'd0);

        // Flush in FULL with InstrReady high
        tick(); Flush = 1'b1; branch_tgt = 32'd128; sample();
        chk("t5_valid", 32'(InstrValid), 32'd1);
        chk("t5_instr", Instr, 32'h0040_0113);
        chk("t5_iaddr", InstrAddr, 32'd64);
        tick(); sample();
        chk("t5_cleared", 32'(InstrValid), 32'd0);
        chk("t5_nop", Instr, NOP);
        chk("t5_relatch_req", 32'(IMemReq), 32'd0);
        tick(); sample();
        chk("t5_req", 32'(IMemReq), 32'd1);
        chk("t5_addr", IMemAddr, 32'd128);
        tick(); sample();
        tick(); Flush = 1'b1; branch_tgt = 32'h42; sample();
        chk("t5_tgt_valid", 32'(InstrValid), 32'd1);
        chk("t5_tgt_instr", Instr, 32'h0080_0113);
        chk("t5_tgt_iaddr", InstrAddr, 32'd128);
        chk("t5_pcen_cnt", 32'(pcen_cnt), 32'd5);

        // Misaligned branch target 0x42
        tick(); sample();
        chk("t6_relatch_req", 32'(IMemReq), 32'd0);
        chk("t6_relatch_empty", 32'(InstrValid), 32'd0);
        tick(); sample();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_fault_valid", 32'(InstrValid), 32'd1);
        chk("t6_fault", 32'(FetchFault), 32'd1);
        chk("t6_fault_iaddr", InstrAddr, 32'h42);
        chk("t6_fault_instr", Instr, NOP);
        chk("t6_fault_no_req", 32'(IMemReq), 32'd0);
        chk("t6_fault_no_pcen", 32'(PCEnable), 32'd0);
`else
        chk("t6_req", 32'(IMemReq), 32'd1);
        chk("t6_addr", IMemAddr, 32'h40);
        chk("t6_no_fault", 32'(FetchFault), 32'd0);
        chk("t6_pcen", 32'(PCEnable), 32'd1);
`endif
        tick(); InstrReady = 1'b0; sample();
        tick(); sample();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_fault_held", 32'(FetchFault), 32'd1);
        chk("t6_fault_held_valid", 32'(InstrValid), 32'd1);
`else
        chk("t6_valid", 32'(InstrValid), 32'd1);
        chk("t6_iaddr", InstrAddr, 32'h40);
        chk("t6_instr", Instr, 32'h0040_0113);
`endif
        repeat (5) begin
            tick(); sample();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
